fixed_point_accumulator: RTL and testbench

//  Downstream consumer of the fixed-point iterative multiplier: accepts its products over val/rdy
//  and sums groups of `len` consecutive products into one n-bit result (dot-product / MAC tail).

---
 rtl/fixed_point_accumulator.sv | 101 ++++++++++
 tb/tb_fixed_point_accumulator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_accumulator.sv
// Sums groups of `len` fixed-point products received over val/rdy and emits one saturated
// n-bit result per group together with a clip flag.
module fixed_point_accumulator #(
  parameter int unsigned n    = 32,
  parameter int unsigned len  = 8,
  parameter bit          sign = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [n-1:0] recv_msg,
  output logic         send_val,
  input  logic         send_rdy,
  output logic [n-1:0] send_msg,
  output logic         send_sat
);

  localparam int unsigned CW = $clog2(len);
  localparam int unsigned W  = n + CW;

  localparam logic [CW-1:0] LastCount = CW'(len - 1);
  localparam logic [CW-1:0] OneCount  = CW'(1);

  typedef enum logic {StAcc, StDone} state_e;

  state_e         r_state;
  logic [W-1:0]   r_acc;
  logic [CW-1:0]  r_count;

  logic [W-1:0]   w_ext;
  logic           w_ovf;
  logic [n-1:0]   w_clip;
  logic [n-1:0]   w_result;
  logic           w_in_acc;
  logic           w_in_done;

  // W = n + clog2(len) leaves enough headroom that the running sum can never wrap.
  always_comb begin
    w_ext = '0;
    if (sign) begin
      w_ext = {{CW{recv_msg[n-1]}}, recv_msg};
    end else begin
      w_ext = {{CW{1'b0}}, recv_msg};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StAcc;
      r_acc   <= '0;
      r_count <= '0;
    end else begin
      unique case (r_state)
        StAcc: begin
          if (recv_val) begin
            r_acc <= r_acc + w_ext;
            if (r_count == LastCount) begin
              r_count <= '0;
              r_state <= StDone;
            end else begin
              r_count <= r_count + OneCount;
            end
          end
        end
        StDone: begin
          if (send_rdy) begin
            r_acc   <= '0;
            r_state <= StAcc;
          end
        end
        default: r_state <= StAcc;
      endcase
    end
  end

  // Signed: in range iff all bits from n-1 upward agree; the top bit picks the clip direction.
  always_comb begin
    w_ovf  = 1'b0;
    w_clip = '1;
    if (sign) begin
      w_ovf  = ~((&r_acc[W-1:n-1]) | ~(|r_acc[W-1:n-1]));
      w_clip = r_acc[W-1] ? {1'b1, {(n-1){1'b0}}} : {1'b0, {(n-1){1'b1}}};
    end else begin
      w_ovf  = |r_acc[W-1:n];
      w_clip = '1;
    end
    w_result = w_ovf ? w_clip : r_acc[n-1:0];
  end

  // Outputs depend only on state and the registered sum; reset forces them quiet immediately.
  always_comb begin
    w_in_acc  = reset && (r_state == StAcc);
    w_in_done = reset && (r_state == StDone);
    recv_rdy  = w_in_acc;
    send_val  = w_in_done;
    send_msg  = w_in_done ? w_result : '0;
    send_sat  = w_in_done & w_ovf;
  end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Bench for fixed_point_accumulator (n=8, len=4): signed and unsigned instances checked
// against an integer-arithmetic model of group sum and saturation.
module tb_fixed_point_accumulator;

  localparam int unsigned N = 8;
  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         recv_val = 1'b0;
  logic [N-1:0] recv_msg = '0;
  logic         send_rdy = 1'b0;
  bit           use_u = 1'b0;

  int tests = 0;
  int failed = 0;

  logic         val_s, rdy_s, srdy_s, sval_s, sat_s;
  logic         val_u, rdy_u, srdy_u, sval_u, sat_u;
  logic [N-1:0] msg_s, msg_u;
  logic         w_rdy, w_val, w_sat;
  logic [N-1:0] w_msg;

  assign val_s  = recv_val & ~use_u;
  assign val_u  = recv_val & use_u;
  assign srdy_s = send_rdy & ~use_u;
  assign srdy_u = send_rdy & use_u;
  assign w_rdy  = use_u ? rdy_u  : rdy_s;
  assign w_val  = use_u ? sval_u : sval_s;
  assign w_msg  = use_u ? msg_u  : msg_s;
  assign w_sat  = use_u ? sat_u  : sat_s;

  fixed_point_accumulator #(.n(N), .len(L), .sign(1'b1)) dut_s (
    .clk      (clk),
    .reset    (reset),
    .recv_val (val_s),
    .recv_rdy (rdy_s),
    .recv_msg (recv_msg),
    .send_val (sval_s),
    .send_rdy (srdy_s),
    .send_msg (msg_s),
    .send_sat (sat_s)
  );

  fixed_point_accumulator #(.n(N), .len(L), .sign(1'b0)) dut_u (
    .clk      (clk),
    .reset    (reset),
    .recv_val (val_u),
    .recv_rdy (rdy_u),
    .recv_msg (recv_msg),
    .send_val (sval_u),
    .send_rdy (srdy_u),
    .send_msg (msg_u),
    .send_sat (sat_u)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1);
  end

  // Reference: exact integer sum, then clip to the n-bit output range.
  function automatic void model(input logic [7:0] v[4], input bit sgn,
                                output logic [7:0] m, output logic s);
    int sum;
    int clip;
    sum = 0;
    for (int i = 0; i < 4; i++) sum += sgn ? int'($signed(v[i])) : int'(v[i]);
    clip = sum;
    if (sgn) begin
      if (sum > 127) clip = 127;
      else if (sum < -128) clip = -128;
    end else if (sum > 255) begin
      clip = 255;
    end
    m = clip[7:0];
    s = (clip != sum);
  endfunction

  function automatic logic [7:0] rand_val();
    logic [7:0] ext [4];
    ext = '{8'h7F, 8'h80, 8'hFF, 8'h00};
    if ($urandom_range(3, 0) == 0) return ext[$urandom_range(3, 0)];
    return 8'($urandom);
  endfunction

  // Called at a negedge; returns at the negedge following the fire.
  task automatic push(input logic [7:0] m);
    int guard;
    guard = 0;
    recv_val = 1'b1;
    recv_msg = m;
    while (!w_rdy && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (w_rdy !== 1'b1) begin
      failed++;
      $display("FAIL push_accept: recv_rdy=%b, required 1 within 20 cycles", w_rdy);
    end
    @(negedge clk);
    recv_val = 1'b0;
  endtask

  task automatic finish_group(input string name);
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    tests++;
    if (w_val !== 1'b0 || w_rdy !== 1'b1) begin
      failed++;
      $display("FAIL %s drain: send_val=%b recv_rdy=%b, required 0/1", name, w_val, w_rdy);
    end
  endtask

  task automatic run_group(input logic [7:0] v[4], input int max_gap, input string name);
    logic [7:0] em;
    logic       es;
    model(v, !use_u, em, es);
    for (int i = 0; i < 4; i++) begin
      push(v[i]);
      if (i < 3) begin
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        tests++;
        if (w_val !== 1'b0) begin
          failed++;
          $display("FAIL %s early_val: after %0d products send_val=%b, required 0",
                   name, i + 1, w_val);
        end
      end
    end
    tests++;
    if (w_val !== 1'b1 || w_rdy !== 1'b0) begin
      failed++;
      $display("FAIL %s latency: send_val=%b recv_rdy=%b, required 1/0", name, w_val, w_rdy);
    end
    tests++;
    if (w_msg !== em || w_sat !== es) begin
      failed++;
      $display("FAIL %s result: send_msg=%h send_sat=%b, required %h/%b",
               name, w_msg, w_sat, em, es);
    end
    finish_group(name);
  endtask

  task automatic check_quiet(input string name);
    tests++;
    if (sval_s !== 1'b0 || rdy_s !== 1'b0 || msg_s !== 8'h00 || sat_s !== 1'b0 ||
        sval_u !== 1'b0 || rdy_u !== 1'b0 || msg_u !== 8'h00 || sat_u !== 1'b0) begin
      failed++;
      $display("FAIL %s quiet: s val/rdy/msg/sat=%b/%b/%h/%b u=%b/%b/%h/%b, required all 0",
               name, sval_s, rdy_s, msg_s, sat_s, sval_u, rdy_u, msg_u, sat_u);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_quiet("reset");
    end
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (rdy_s !== 1'b1 || rdy_u !== 1'b1 || sval_s !== 1'b0 || sval_u !== 1'b0) begin
      failed++;
      $display("FAIL reset_release: rdy s/u=%b/%b val s/u=%b/%b, required 1/1 0/0",
               rdy_s, rdy_u, sval_s, sval_u);
    end
  endtask

  task automatic test_signed_directed();
    logic [7:0] g [4];
    use_u = 1'b0;
    g = '{8'h10, 8'h10, 8'h10, 8'h10};
    run_group(g, 0, "signed_basic");
    g = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};
    run_group(g, 0, "signed_pos_sat");
    g = '{8'h80, 8'h80, 8'h80, 8'h80};
    run_group(g, 0, "signed_neg_sat");
    g = '{8'hF0, 8'h20, 8'hFF, 8'h01};
    run_group(g, 0, "signed_excursion");
  endtask

  task automatic test_unsigned_directed();
    logic [7:0] g [4];
    use_u = 1'b1;
    g = '{8'hFF, 8'h01, 8'h00, 8'h00};
    run_group(g, 0, "unsigned_sat");
    g = '{8'h40, 8'h40, 8'h40, 8'h3F};
    run_group(g, 0, "unsigned_full");
    use_u = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] g [4];
    logic [7:0] em;
    logic       es;
    use_u = 1'b0;
    for (int i = 0; i < 4; i++) g[i] = rand_val();
    model(g, 1'b1, em, es);
    for (int i = 0; i < 4; i++) push(g[i]);
    recv_val = 1'b1;
    recv_msg = 8'h05;
    send_rdy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (w_val !== 1'b1 || w_rdy !== 1'b0 || w_msg !== em || w_sat !== es) begin
        failed++;
        $display("FAIL backpressure_hold: val=%b rdy=%b msg=%h sat=%b, required 1/0/%h/%b",
                 w_val, w_rdy, w_msg, w_sat, em, es);
      end
    end
    finish_group("backpressure");
    // 0x05 has been held on recv_msg throughout and must open the next group.
    g[0] = 8'h05;
    for (int i = 1; i < 4; i++) g[i] = rand_val();
    run_group(g, 0, "backpressure_next");
  endtask

  task automatic test_random_sparse();
    logic [7:0] g [4];
    for (int k = 0; k < 24; k++) begin
      use_u = k[0];
      for (int i = 0; i < 4; i++) g[i] = rand_val();
      run_group(g, 3, use_u ? "rand_unsigned" : "rand_signed");
    end
    use_u = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] g [4];
    use_u = 1'b0;
    push(8'h33);
    push(8'h44);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_quiet("reset_mid");
    end
    reset = 1'b1;
    @(negedge clk);
    g = '{8'h01, 8'h01, 8'h01, 8'h01};
    run_group(g, 0, "after_reset_mid");
    for (int i = 0; i < 4; i++) push(8'h22);
    reset = 1'b0;
    @(negedge clk);
    check_quiet("reset_done");
    reset = 1'b1;
    @(negedge clk);
    g = '{8'h02, 8'hFE, 8'h03, 8'h01};
    run_group(g, 1, "after_reset_done");
  endtask

  initial begin
    test_reset();
    test_signed_directed();
    test_unsigned_directed();
    test_backpressure();
    test_random_sparse();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
